// File: rtl/data_sram_pkg.sv
// Shared types for the data SRAM arbiter and its store buffer.
//   sb_entry_t : one posted store {addr, byte enables, data}
//   sel_e      : which requester owns the SRAM port this cycle
//   fence_e    : fence sequencer states
//   same_word  : word-address (bits [31:2]) equality used by the RAW check
package data_sram_pkg;

  localparam int ADDR_W        = 32;
  localparam int DATA_W        = 32;
  localparam int BE_W          = 4;
  localparam int WORD_ADDR_LSB = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BE_W-1:0]   we;
    logic [DATA_W-1:0] wdata;
  } sb_entry_t;

  typedef enum logic [1:0] {
    SEL_IDLE = 2'd0,
    SEL_LD   = 2'd1,
    SEL_ST   = 2'd2
  } sel_e;

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_DRAIN = 2'd1,
    F_DONE  = 2'd2
  } fence_e;

  function automatic logic same_word(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
    return a[ADDR_W-1:WORD_ADDR_LSB] == b[ADDR_W-1:WORD_ADDR_LSB];
  endfunction

endpackage

// File: rtl/store_buffer.sv
// Circular FIFO of posted stores with per-entry valid bits.
// Ports:
//   push_i/push_entry_i   enqueue one store at the write pointer
//   pop_i                 retire the head entry (it is on the SRAM port this cycle)
//   cmp_valid_i/cmp_addr_i store being accepted this cycle, included in the RAW compare
//   ld_addr_i             load address compared against every pending store
//   head_o                oldest pending store
//   count_o/count_next_o  occupancy now and after this cycle's push/pop
//   full_o/empty_o        occupancy flags
//   conflict_o            load hits the word of a pending or incoming store
module store_buffer
  import data_sram_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  localparam int PTR_W = $clog2(SB_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push_i,
  input  sb_entry_t         push_entry_i,
  input  logic              cmp_valid_i,
  input  logic [ADDR_W-1:0] cmp_addr_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  output sb_entry_t         head_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [CNT_W-1:0]  count_next_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              conflict_o
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SB_DEPTH);

  sb_entry_t             entries_q [SB_DEPTH];
  logic [SB_DEPTH-1:0]   valid_q;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic                  conflict_s;

  // Occupancy after this cycle; simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    if (push_i && !pop_i) begin
      count_d = count_q + CNT_ONE;
    end else if (!push_i && pop_i) begin
      count_d = count_q - CNT_ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Parallel word compare; the incoming store is older than the load in program order.
  always_comb begin
    conflict_s = cmp_valid_i && same_word(cmp_addr_i, ld_addr_i);
    for (int i = 0; i < SB_DEPTH; i++) begin
      conflict_s = conflict_s | (valid_q[i] && same_word(entries_q[i].addr, ld_addr_i));
    end
  end

  // Pointers, valid bits and count; reset discards every pending store.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q  <= {SB_DEPTH{1'b0}};
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      if (pop_i) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PTR_ONE;
      end
      if (push_i) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PTR_ONE;
      end
      count_q <= count_d;
    end
  end

  // Entry payload storage; validity is tracked separately so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_i) begin
      entries_q[wr_ptr_q] <= push_entry_i;
    end
  end

  assign head_o       = entries_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign full_o       = (count_q == CNT_FULL);
  assign empty_o      = (count_q == {CNT_W{1'b0}});
  assign conflict_o   = conflict_s;

endmodule

// File: rtl/data_sram_arbiter.sv
// Owner of the single data SRAM port. Loads take the port first; stores are
// posted into a store buffer and drained in idle cycles, when the buffer is
// full, or while a fence is draining. Loads that hit a pending store's word
// wait until that store has drained.
// Ports:
//   ld_req/ld_addr -> ld_ack (same cycle), ld_rdata_valid/ld_rdata (next cycle)
//   st_req/st_addr/st_we/st_wdata -> st_ready (accept handshake)
//   fence_req (level) -> fence_done (one-cycle pulse when the buffer is empty)
//   sb_count        occupied store buffer entries
//   data_sram_*     SRAM pins, read data has one cycle of latency
module data_sram_arbiter
  import data_sram_pkg::*;
#(
  parameter int SB_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ld_req,
  input  logic [31:0]                ld_addr,
  output logic                       ld_ack,
  output logic                       ld_rdata_valid,
  output logic [31:0]                ld_rdata,
  input  logic                       st_req,
  input  logic [31:0]                st_addr,
  input  logic [3:0]                 st_we,
  input  logic [31:0]                st_wdata,
  output logic                       st_ready,
  input  logic                       fence_req,
  output logic                       fence_done,
  output logic [$clog2(SB_DEPTH):0]  sb_count,
  output logic                       data_sram_en,
  output logic [3:0]                 data_sram_we,
  output logic [31:0]                data_sram_addr,
  output logic [31:0]                data_sram_wdata,
  input  logic [31:0]                data_sram_rdata
);

  localparam int CNT_W = $clog2(SB_DEPTH) + 1;

  sb_entry_t         head_s;
  sb_entry_t         push_entry_s;
  logic [CNT_W-1:0]  count_s;
  logic [CNT_W-1:0]  count_next_s;
  logic              full_s;
  logic              empty_s;
  logic              conflict_s;
  logic              accept_s;
  logic              push_s;
  sel_e              sel_s;
  fence_e            fence_q;
  fence_e            fence_d;
  logic              fence_done_q;
  logic              ld_rdata_valid_q;

  assign st_ready     = !full_s && (fence_q == F_IDLE);
  assign accept_s     = st_req && st_ready;
  // A zero byte-enable store is consumed without occupying an entry.
  assign push_s       = accept_s && (st_we != 4'h0);
  assign push_entry_s = '{addr: st_addr, we: st_we, wdata: st_wdata};

  store_buffer #(
    .SB_DEPTH (SB_DEPTH)
  ) u_store_buffer (
    .clk          (clk),
    .resetn       (resetn),
    .push_i       (push_s),
    .push_entry_i (push_entry_s),
    .cmp_valid_i  (accept_s),
    .cmp_addr_i   (st_addr),
    .pop_i        (sel_s == SEL_ST),
    .ld_addr_i    (ld_addr),
    .head_o       (head_s),
    .count_o      (count_s),
    .count_next_o (count_next_s),
    .full_o       (full_s),
    .empty_o      (empty_s),
    .conflict_o   (conflict_s)
  );

  // Fixed-priority port select: forced drain, then load, then opportunistic drain.
  always_comb begin
    sel_s = SEL_IDLE;
    if ((full_s || (fence_q == F_DRAIN)) && !empty_s) begin
      sel_s = SEL_ST;
    end else if (ld_req && !conflict_s && (fence_q == F_IDLE)) begin
      sel_s = SEL_LD;
    end else if (!empty_s) begin
      sel_s = SEL_ST;
    end else begin
      sel_s = SEL_IDLE;
    end
  end

  // SRAM pin drive for the selected requester; idle cycles drive all zeros.
  always_comb begin
    ld_ack          = 1'b0;
    data_sram_en    = 1'b0;
    data_sram_we    = 4'h0;
    data_sram_addr  = {ADDR_W{1'b0}};
    data_sram_wdata = {DATA_W{1'b0}};
    case (sel_s)
      SEL_LD: begin
        ld_ack         = 1'b1;
        data_sram_en   = 1'b1;
        data_sram_addr = ld_addr;
      end
      SEL_ST: begin
        data_sram_en    = 1'b1;
        data_sram_we    = head_s.we;
        data_sram_addr  = head_s.addr;
        data_sram_wdata = head_s.wdata;
      end
      default: begin
        ld_ack = 1'b0;
      end
    endcase
  end

  // Fence sequencing; looking at next-cycle occupancy lets the final drain
  // cycle (or an already empty buffer) go straight to DONE.
  always_comb begin
    fence_d = fence_q;
    case (fence_q)
      F_IDLE: begin
        if (fence_req) begin
          fence_d = (count_next_s == {CNT_W{1'b0}}) ? F_DONE : F_DRAIN;
        end else begin
          fence_d = F_IDLE;
        end
      end
      F_DRAIN: fence_d = (count_next_s == {CNT_W{1'b0}}) ? F_DONE : F_DRAIN;
      F_DONE:  fence_d = fence_req ? F_DRAIN : F_IDLE;
      default: fence_d = F_IDLE;
    endcase
  end

  // Fence state plus the registered fence_done and read-valid outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fence_q          <= F_IDLE;
      fence_done_q     <= 1'b0;
      ld_rdata_valid_q <= 1'b0;
    end else begin
      fence_q          <= fence_d;
      fence_done_q     <= (fence_d == F_DONE);
      ld_rdata_valid_q <= (sel_s == SEL_LD);
    end
  end

  assign fence_done     = fence_done_q;
  assign ld_rdata_valid = ld_rdata_valid_q;
  assign ld_rdata       = data_sram_rdata;
  assign sb_count       = count_s;

endmodule

// File: tb/tb_data_sram_arbiter.sv
module tb_data_sram_arbiter;

  localparam int DEPTH = 4;
  localparam int NV    = 22;
  localparam logic [31:0] RBASE = 32'h0001_0000;

  logic        clk, resetn;
  logic        ld_req, ld_ack, ld_rdata_valid;
  logic [31:0] ld_addr, ld_rdata;
  logic        st_req, st_ready;
  logic [31:0] st_addr, st_wdata;
  logic [3:0]  st_we;
  logic        fence_req, fence_done;
  logic [$clog2(DEPTH):0] sb_count;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;

  int checks   = 0;
  int failures = 0;

  data_sram_arbiter #(.SB_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_ack(ld_ack),
    .ld_rdata_valid(ld_rdata_valid), .ld_rdata(ld_rdata),
    .st_req(st_req), .st_addr(st_addr), .st_we(st_we), .st_wdata(st_wdata),
    .st_ready(st_ready), .fence_req(fence_req), .fence_done(fence_done),
    .sb_count(sb_count), .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // SRAM model: byte-enabled writes, one-cycle read latency, unwritten words read 0.
  logic [31:0] mem [bit [29:0]];
  initial data_sram_rdata = 32'h0;
  always @(posedge clk) begin
    if (data_sram_en) begin
      if (data_sram_we != 4'h0)
        mem[data_sram_addr[31:2]] = merge(mem.exists(data_sram_addr[31:2]) ? mem[data_sram_addr[31:2]] : 32'h0,
                                          data_sram_we, data_sram_wdata);
      else
        data_sram_rdata <= mem.exists(data_sram_addr[31:2]) ? mem[data_sram_addr[31:2]] : 32'h0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic l, input logic [31:0] la, input logic s, input logic [31:0] sa,
                       input logic [3:0] swe, input logic [31:0] sd, input logic f);
    ld_req = l; ld_addr = la; st_req = s; st_addr = sa; st_we = swe; st_wdata = sd; fence_req = f;
  endtask

  typedef struct {
    logic ld; logic [31:0] la; logic st; logic [31:0] sa; logic [3:0] swe; logic [31:0] sd; logic fence;
    logic e_ack; logic e_rdy; logic e_en; logic [3:0] e_we; logic [31:0] e_addr; logic [31:0] e_wd;
    int e_cnt; logic e_rv; logic [31:0] e_rd; logic e_fd;
  } vec_t;
  vec_t vt [NV];

  typedef struct packed { logic [31:0] a; logic [3:0] we; logic [31:0] d; } st_t;
  st_t         sbq [$];
  st_t         ent;
  logic [31:0] arch [bit [29:0]];
  int          fph, mode, n;
  logic        exp_rv, exp_fd, last_ack, e_rdy, acc, conf;
  logic        l, s, f;
  logic [31:0] la, sa, sd, exp_rd, e_addr, e_wd;
  logic [3:0]  swe, e_we;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    //         ld    la            st    sa            we    sd             fn    ack   rdy   en    we    addr          wdata          cnt rv    rdata          fd
    vt[0]  = '{1'b1, 32'h1000, 1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 32'h1000, 32'h0,        0, 1'b1, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 32'h0,    1'b1, 32'h2000, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0,    32'h0,        1, 1'b0, 32'h0,        1'b0};
    vt[2]  = '{1'b1, 32'h2000, 1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 32'h2000, 32'hDEADBEEF, 0, 1'b0, 32'h0,        1'b0};
    vt[3]  = '{1'b1, 32'h2000, 1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 32'h2000, 32'h0,        0, 1'b1, 32'hDEADBEEF, 1'b0};
    vt[4]  = '{1'b1, 32'h3006, 1'b1, 32'h3004, 4'hF, 32'h11112222, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0,    32'h0,        1, 1'b0, 32'h0,        1'b0};
    vt[5]  = '{1'b1, 32'h3006, 1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 1'b0, 1'b1, 1'b1, 4'hF, 32'h3004, 32'h11112222, 0, 1'b0, 32'h0,        1'b0};
    vt[6]  = '{1'b1, 32'h3006, 1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 32'h3006, 32'h0,        0, 1'b1, 32'h11112222, 1'b0};
    vt[7]  = '{1'b1, 32'h4000, 1'b1, 32'h5000, 4'hF, 32'h1,        1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 32'h4000, 32'h0,        1, 1'b1, 32'h0,        1'b0};
    vt[8]  = '{1'b1, 32'h4000, 1'b1, 32'h5004, 4'hF, 32'h2,        1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 32'h4000, 32'h0,        2, 1'b1, 32'h0,        1'b0};
    vt[9]  = '{1'b1, 32'h4000, 1'b1, 32'h5008, 4'hF, 32'h3,        1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 32'h4000, 32'h0,        3, 1'b1, 32'h0,        1'b0};
    vt[10] = '{1'b1, 32'h4000, 1'b1, 32'h500C, 4'hF, 32'h4,        1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 32'h4000, 32'h0,        4, 1'b1, 32'h0,        1'b0};
    vt[11] = '{1'b1, 32'h4000, 1'b1, 32'h5010, 4'hF, 32'h5,        1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 32'h5000, 32'h1,        3, 1'b0, 32'h0,        1'b0};
    vt[12] = '{1'b1, 32'h4000, 1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 32'h4000, 32'h0,        3, 1'b1, 32'h0,        1'b0};
    vt[13] = '{1'b1, 32'h4000, 1'b0, 32'h0,    4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 32'h4000, 32'h0,        3, 1'b1, 32'h0,        1'b0};
    vt[14] = '{1'b1, 32'h4000, 1'b0, 32'h0,    4'h0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 32'h5004, 32'h2,        2, 1'b0, 32'h0,        1'b0};
    vt[15] = '{1'b1, 32'h4000, 1'b0, 32'h0,    4'h0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 32'h5008, 32'h3,        1, 1'b0, 32'h0,        1'b0};
    vt[16] = '{1'b1, 32'h4000, 1'b0, 32'h0,    4'h0, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 32'h500C, 32'h4,        0, 1'b0, 32'h0,        1'b1};
    vt[17] = '{1'b1, 32'h4000, 1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        0, 1'b0, 32'h0,        1'b0};
    vt[18] = '{1'b1, 32'h4000, 1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 32'h4000, 32'h0,        0, 1'b1, 32'h0,        1'b0};
    vt[19] = '{1'b0, 32'h0,    1'b0, 32'h0,    4'h0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0,    32'h0,        0, 1'b0, 32'h0,        1'b1};
    vt[20] = '{1'b0, 32'h0,    1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0,    32'h0,        0, 1'b0, 32'h0,        1'b0};
    vt[21] = '{1'b1, 32'h1000, 1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 32'h1000, 32'h0,        0, 1'b1, 32'h0,        1'b0};

    // Reset state
    resetn = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset sb_count", 32'(sb_count), 32'd0);
    chk("reset ld_rdata_valid", 32'(ld_rdata_valid), 32'd0);
    chk("reset fence_done", 32'(fence_done), 32'd0);
    chk("reset data_sram_en", 32'(data_sram_en), 32'd0);
    chk("reset st_ready", 32'(st_ready), 32'd1);
    @(negedge clk);
    resetn = 1'b1;

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i].ld, vt[i].la, vt[i].st, vt[i].sa, vt[i].swe, vt[i].sd, vt[i].fence);
      #1;
      chk($sformatf("v%0d ld_ack", i), 32'(ld_ack), 32'(vt[i].e_ack));
      chk($sformatf("v%0d st_ready", i), 32'(st_ready), 32'(vt[i].e_rdy));
      chk($sformatf("v%0d sram_en", i), 32'(data_sram_en), 32'(vt[i].e_en));
      chk($sformatf("v%0d sram_we", i), 32'(data_sram_we), 32'(vt[i].e_we));
      chk($sformatf("v%0d sram_addr", i), data_sram_addr, vt[i].e_addr);
      if (!vt[i].e_ack) chk($sformatf("v%0d sram_wdata", i), data_sram_wdata, vt[i].e_wd);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d sb_count", i), 32'(sb_count), 32'(vt[i].e_cnt));
      chk($sformatf("v%0d rdata_valid", i), 32'(ld_rdata_valid), 32'(vt[i].e_rv));
      chk($sformatf("v%0d fence_done", i), 32'(fence_done), 32'(vt[i].e_fd));
      if (vt[i].e_rv) chk($sformatf("v%0d ld_rdata", i), ld_rdata, vt[i].e_rd);
    end

    // Reset with three pending stores: discarded at once, never drained later
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, 32'h7000, 1'b1, 32'h6000 + 32'(k * 4), 4'hF, 32'hA0 + 32'(k), 1'b0);
      @(posedge clk);
      #1;
    end
    chk("pre-reset sb_count", 32'(sb_count), 32'd3);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    #1;
    resetn = 1'b0;
    #1;
    chk("async reset sb_count", 32'(sb_count), 32'd0);
    chk("async reset sram_en", 32'(data_sram_en), 32'd0);
    chk("async reset rdata_valid", 32'(ld_rdata_valid), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post-reset%0d sram_en", k), 32'(data_sram_en), 32'd0);
      chk($sformatf("post-reset%0d sb_count", k), 32'(sb_count), 32'd0);
    end

    // Randomized traffic against a program-order reference model
    l = 1'b0; la = 32'h0; f = 1'b0; last_ack = 1'b0;
    fph = 0; exp_rv = 1'b0; exp_fd = 1'b0; exp_rd = 32'h0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (!l || last_ack) begin
        l  = ($urandom_range(0, 3) != 0);
        la = RBASE + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
      end
      s   = ($urandom_range(0, 1) == 1);
      sa  = RBASE + 32'($urandom_range(0, 7) << 2) + 32'($urandom_range(0, 3));
      swe = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      sd  = $urandom();
      if ($urandom_range(0, 24) == 0) f = !f;
      drive(l, la, s, sa, swe, sd, f);
      #1;
      n     = sbq.size();
      e_rdy = (n < DEPTH) && (fph == 0);
      acc   = s && e_rdy;
      conf  = acc && (sa[31:2] == la[31:2]);
      foreach (sbq[j]) if (sbq[j].a[31:2] == la[31:2]) conf = 1'b1;
      if (((n == DEPTH) || (fph == 1)) && (n > 0)) mode = 2;
      else if (l && !conf && (fph == 0))          mode = 1;
      else if (n > 0)                              mode = 2;
      else                                         mode = 0;
      e_we = 4'h0; e_addr = 32'h0; e_wd = 32'h0;
      if (mode == 1) e_addr = la;
      if (mode == 2) begin e_we = sbq[0].we; e_addr = sbq[0].a; e_wd = sbq[0].d; end
      chk("rnd ld_ack", 32'(ld_ack), 32'(mode == 1));
      chk("rnd st_ready", 32'(st_ready), 32'(e_rdy));
      chk("rnd sram_en", 32'(data_sram_en), 32'(mode != 0));
      chk("rnd sram_we", 32'(data_sram_we), 32'(e_we));
      chk("rnd sram_addr", data_sram_addr, e_addr);
      if (mode != 1) chk("rnd sram_wdata", data_sram_wdata, e_wd);
      @(posedge clk);
      exp_rv = (mode == 1);
      if (mode == 1) exp_rd = arch.exists(la[31:2]) ? arch[la[31:2]] : 32'h0;
      if (mode == 2) void'(sbq.pop_front());
      if (acc && (swe != 4'h0)) begin
        ent = '{a: sa, we: swe, d: sd};
        sbq.push_back(ent);
        arch[sa[31:2]] = merge(arch.exists(sa[31:2]) ? arch[sa[31:2]] : 32'h0, swe, sd);
      end
      case (fph)
        0:       if (f) fph = (sbq.size() == 0) ? 2 : 1;
        1:       if (sbq.size() == 0) fph = 2;
        default: fph = f ? 1 : 0;
      endcase
      exp_fd   = (fph == 2);
      last_ack = (mode == 1);
      #1;
      chk("rnd sb_count", 32'(sb_count), 32'(sbq.size()));
      chk("rnd rdata_valid", 32'(ld_rdata_valid), 32'(exp_rv));
      chk("rnd fence_done", 32'(fence_done), 32'(exp_fd));
      if (exp_rv) chk("rnd ld_rdata", ld_rdata, exp_rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_sram_arbiter.md
Name: data_sram_arbiter

Overview:
Owns the single data SRAM port that loads (issued from ID/EXE) and stores (issued from MEM) currently share. Today the two requesters are muxed and conflicts raise a pipeline stall. This block replaces that with a posted store buffer plus a fixed-priority arbiter. Loads get the port first; stores drain in idle cycles or when the buffer fills; read-after-write ordering is preserved by address compare against pending stores. It sits between the pipeline top and the data_sram_* pins.

Parameters:
SB_DEPTH, 4, store buffer entries (power of two, 2..16)
ADDR_W, 32, byte address width
DATA_W, 32, data width (fixed 32; 4 byte-enables)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
ld_req  in  1  load wants the port this cycle
ld_addr  in  32  load byte address
ld_ack  out  1  load granted this cycle (SRAM en driven with ld_addr)
ld_rdata_valid  out  1  registered; high the cycle after ld_ack
ld_rdata  out  32  data_sram_rdata passthrough, valid with ld_rdata_valid
st_req  in  1  store offered
st_addr  in  32  store byte address
st_we  in  4  store byte enables
st_wdata  in  32  store data
st_ready  out  1  store accepted when st_req && st_ready
fence_req  in  1  level; drain all stores, block loads
fence_done  out  1  one-cycle pulse when drain completes
sb_count  out  $clog2(SB_DEPTH)+1  occupied entries
data_sram_en  out  1  SRAM enable
data_sram_we  out  4  SRAM byte write enable
data_sram_addr  out  32  SRAM address
data_sram_wdata  out  32  SRAM write data
data_sram_rdata  in  32  SRAM read data, 1-cycle latency

Behaviour:
- Reset (async assert, sync deassert): wr/rd pointers 0, sb_count 0, all entries invalid, ld_rdata_valid 0, fence FSM IDLE, fence_done 0. Reset during operation discards all pending stores.
- Enqueue: st_ready = (sb_count < SB_DEPTH) && fence FSM == IDLE. On accept with st_we != 0, write {addr, we, wdata} at wr_ptr, increment wr_ptr (wraps mod SB_DEPTH). An accept with st_we == 0 is consumed and not enqueued.
- Conflict: ld_conflict = ld_addr[31:2] equals addr[31:2] of any valid entry, or of the store being accepted this cycle (that store is older in program order).
- Port select, evaluated combinationally each cycle, in priority order:
  1. Buffer full, or fence FSM in DRAIN -> drain head.
  2. ld_req && !ld_conflict && fence IDLE -> load.
  3. Buffer not empty -> drain head.
  4. Otherwise idle: data_sram_en = 0, data_sram_we = 0, addr/wdata = 0.
- Load grant: en = 1, we = 0, addr = ld_addr, ld_ack = 1. ld_rdata_valid is set the next cycle. There is no latency beyond SRAM.
- Drain: en = 1, we = head.we, addr = head.addr, wdata = head.wdata. Increment rd_ptr and decrement count. Same-cycle enqueue and drain leave the count unchanged.
- A load that is denied (conflict, full, or fence) keeps ld_ack = 0. The requester holds ld_req and ld_addr stable until ack.
- Fence FSM:
  - IDLE -> DRAIN on fence_req.
  - DRAIN -> DONE when the count reaches 0, including the cycle the last entry drains.
  - DONE pulses fence_done for one cycle, then returns to IDLE. If fence_req is still high, it returns to DRAIN instead (re-arm).
  - fence_req with an empty buffer reaches DONE on the next cycle.
- Invariants: sb_count ≤ SB_DEPTH; data_sram_we ≠ 0 implies data_sram_en = 1; ld_ack and a store drain are never both active in one cycle.

Decomposition:
- Shared package data_sram_pkg:
  - SB entry struct {addr[31:0], we[3:0], wdata[31:0]}
  - sel enum {SEL_IDLE, SEL_LD, SEL_ST}
  - fence enum {F_IDLE, F_DRAIN, F_DONE}
  - WORD_ADDR_LSB = 2
- One sub-module, store_buffer: circular FIFO storage, valid bits, pointers, count, and the parallel word-address compare (conflict output).
- The arbiter and fence FSM live in data_sram_arbiter.

Test Plan:
- Empty buffer, ld_req addr 0x1000 -> ld_ack same cycle, data_sram_en = 1, we = 0; next cycle ld_rdata_valid = 1 with the SRAM value.
- Store 0x2000/we = F/0xDEADBEEF, then load 0x2000 next cycle -> load held (ack = 0) until the drain cycle with we = F; then ack; read returns 0xDEADBEEF.
- Same-cycle store 0x3004 and load 0x3006 -> conflict, no ack that cycle; store drains; load acks after.
- Four stores with continuous load requests to unrelated addresses -> count hits 4, st_ready = 0, drain forced over the load; count returns to 3 and the load acks the following cycle.
- Three stores pending, fence_req raised -> loads blocked, three drain cycles, fence_done pulses exactly once, count = 0.
- resetn asserted with three entries pending -> count = 0 and data_sram_en = 0 immediately; no drain of stale entries after release.
